lsu: RTL and testbench
======================

Name: lsu

Overview:
- Multi-cycle load/store unit directly downstream of the ALU in the NPC core.
- Takes the ALU result as the effective address, plus store data and funct3 from decode.
- Performs one transaction on a simple req/gnt + rvalid data-memory bus.
- Returns sign/zero-extended load data (or a store acknowledge) to writeback over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of in_addr and mem_addr.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request from execute stage.
- in_ready  output  1  LSU can accept a request.
- in_addr  input  ADDR_W  effective address (ALU add result).
- in_wdata  input  XLEN  store data (rs2 value).
- in_we  input  1  1 = store, 0 = load.
- in_funct3  input  3  RV32I width/sign: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010.
- out_valid  output  1  result available to writeback.
- out_ready  input  1  writeback accepts the result.
- out_rdata  output  XLEN  extended load data; 0 for stores.
- out_err  output  1  misaligned access flag (see Optional Feature).
- mem_req  output  1  bus request.
- mem_gnt  input  1  bus grant.
- mem_we  output  1  bus write enable.
- mem_addr  output  ADDR_W  word-aligned address ({in_addr[ADDR_W-1:2],2'b00}).
- mem_wmask  output  4  byte-lane strobe.
- mem_wdata  output  XLEN  store data replicated to the addressed lanes.
- mem_rvalid  input  1  read data / write acknowledge.
- mem_rdata  input  XLEN  read word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset (rst_n low, asynchronous) forces IDLE.
- Reset values: in_ready=1; out_valid=0, out_rdata=0, out_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wmask=0, mem_wdata=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch addr, wdata, we, funct3, then go to REQ.
  - A misaligned request with the check enabled goes to RESP instead.
- REQ:
  - mem_req=1; address, mask and data are held stable until mem_gnt.
  - On mem_gnt go to WAIT; mem_req drops the following cycle.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: for loads, capture the extended data into out_rdata; for stores, out_rdata=0. Then go to RESP.
- RESP:
  - out_valid=1; out_rdata and out_err are held stable while out_ready=0.
  - On out_ready go to IDLE; in_ready rises the next cycle (no same-cycle re-accept).
- in_ready is 0 in REQ, WAIT and RESP. Exactly one outstanding transaction at a time.
- mem_rvalid is ignored outside WAIT. The bus guarantees rvalid at least one cycle after gnt.
- Minimum latency, accept to out_valid: 3 cycles (accept at C0, REQ at C1 with gnt, WAIT at C2 with rvalid, RESP at C3).
- Lane/extension rules, with off = addr[1:0]:
  - Byte: mask = 4'b0001<<off; wdata byte replicated to all 4 lanes; load takes byte off, sign-extended for LB, zero-extended for LBU.
  - Half: mask = 4'b0011<<off; halfword replicated to both halves; load takes halfword off[1]; LH sign-extends, LHU zero-extends.
  - Word: mask = 4'b1111.
- Loads drive mem_wmask=0 and mem_we=0.
- Unknown funct3 is treated as word.
- Reset mid-transaction returns immediately to IDLE and drops mem_req. The bus is expected to be reset by the same rst_n.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, issues no bus request.
  - FSM goes IDLE->RESP with out_err=1 and out_rdata=0.
- Undefined:
  - out_err is tied to 0.
  - Low offset bits beyond the access size are ignored: half uses addr[1], word uses offset 0.

Decomposition:
- npc_pkg holds:
  - funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, REQ, WAIT, RESP}.
  - XLEN.
- One natural combinational sub-module, lsu_align:
  - Store path: funct3 + offset + wdata -> wmask/wdata.
  - Load path: funct3 + offset + rdata -> extended result.
  - Instantiated twice, or once with both paths.

Test Plan:
- LW addr 0x80000004, rdata 0xDEADBEEF, gnt and rvalid at first opportunity -> out_valid on C3, out_rdata 0xDEADBEEF, mem_addr 0x80000004, mem_wmask 0.
- LB addr 0x80000003, rdata 0x80FF1234 -> out_rdata 0xFFFFFF80; LBU same address -> 0x00000080.
- SH addr 0x80000002, wdata 0x0000ABCD -> mem_we=1, mem_wmask 4'b1100, mem_wdata 0xABCDABCD; out_rdata 0 after rvalid.
- gnt delayed 3 cycles and out_ready held low 4 cycles -> mem_req/addr stable until gnt; out_valid/out_rdata stable; in_ready=0 throughout.
- rst_n pulsed low while in WAIT -> immediately in_ready=1, mem_req=0, out_valid=0; a later rvalid is ignored.
- With LSU_MISALIGN_CHECK_EN, LW addr 0x80000002 -> no mem_req; out_valid next cycle with out_err=1, out_rdata=0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC core types for the load/store unit: funct3 encodings, FSM
// states and the latched request record.
package npc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Request fields still needed after the bus phase has been set up
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

  // Half accesses must be 2-byte aligned and word (or unknown) accesses 4-byte aligned
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = off[0];
      default:     misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe generation and load data
// extraction with sign/zero extension. Purely combinational.
module lsu_align
  import npc_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wmask_c,
  output logic [XLEN-1:0] st_wdata_c,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_rdata_c
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Store path: strobe shifted to the addressed lanes, data replicated
  always_comb begin
    st_wmask_c = 4'b1111;
    st_wdata_c = st_wdata;
    case (st_funct3)
      F3_B: begin
        st_wmask_c = 4'b0001 << st_off;
        st_wdata_c = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_wmask_c = 4'b0011 << {st_off[1], 1'b0};
        st_wdata_c = {2{st_wdata[15:0]}};
      end
      default: begin
        st_wmask_c = 4'b1111;
        st_wdata_c = st_wdata;
      end
    endcase
  end

  // Load path: pick the addressed byte/half and extend per funct3
  always_comb begin
    ld_b       = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_h       = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_rdata_c = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_rdata_c = {{(XLEN-8){ld_b[7]}}, ld_b};
      F3_BU:   ld_rdata_c = {{(XLEN-8){1'b0}}, ld_b};
      F3_H:    ld_rdata_c = {{(XLEN-16){ld_h[15]}}, ld_h};
      F3_HU:   ld_rdata_c = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_rdata_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one req/gnt + rvalid bus transaction per
// accepted request, result returned over a valid/ready handshake.
// Optional: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with out_err=1 and no bus request.
module lsu
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              in_ready_d, out_valid_d, out_err_d;
  logic              mem_req_d, mem_we_d;
  logic [XLEN-1:0]   out_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_wmask_d;

  logic [3:0]        st_wmask_c;
  logic [XLEN-1:0]   st_wdata_c;
  logic [XLEN-1:0]   ld_rdata_c;

  lsu_align u_align (
    .st_funct3  (in_funct3),
    .st_off     (in_addr[1:0]),
    .st_wdata   (in_wdata),
    .st_wmask_c (st_wmask_c),
    .st_wdata_c (st_wdata_c),
    .ld_funct3  (req_q.funct3),
    .ld_off     (req_q.off),
    .ld_rdata   (mem_rdata),
    .ld_rdata_c (ld_rdata_c)
  );

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_rdata_d = out_rdata;
    out_err_d   = out_err;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wmask_d = mem_wmask;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          req_d       = '{we: in_we, funct3: in_funct3, off: in_addr[1:0]};
          in_ready_d  = 1'b0;
          out_err_d   = 1'b0;
          mem_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
          mem_we_d    = in_we;
          mem_wmask_d = in_we ? st_wmask_c : 4'b0000;
          mem_wdata_d = in_we ? st_wdata_c : '0;
          mem_req_d   = 1'b1;
          state_d     = REQ;
`ifdef LSU_MISALIGN_CHECK_EN
          if (misaligned(in_funct3, in_addr[1:0])) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_wmask_d = 4'b0000;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = '0;
            state_d     = RESP;
          end
`endif
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = req_q.we ? '0 : ld_rdata_c;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_rdata <= out_rdata_d;
      out_err   <= out_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wmask <= mem_wmask_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of load/store vectors plus hand sequences
// for stalls, mid-transaction reset and (optionally) misalignment.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_we;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_we      (in_we),
    .in_funct3  (in_funct3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdata  (out_rdata),
    .out_err    (out_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] ea,
                     input logic [3:0] em, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.name = n; v.we = we; v.funct3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.exp_addr = ea; v.exp_wmask = em; v.exp_wdata = ewd; v.exp_rdata = erd;
    vecs.push_back(v);
  endtask

  // One full transaction with gnt delayed gnt_dly cycles and out_ready delayed rdy_dly cycles
  task automatic run_txn(input vec_t v, input int gnt_dly, input int rdy_dly);
    @(negedge clk);
    check({v.name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_addr = v.addr; in_wdata = v.wdata; in_we = v.we; in_funct3 = v.funct3;
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = 32'hFFFF_FFFF; in_wdata = 32'h1357_9BDF; in_we = ~v.we;
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      check({v.name, "_req"}, 32'(mem_req), 32'd1);
      check({v.name, "_addr"}, mem_addr, v.exp_addr);
      check({v.name, "_we"}, 32'(mem_we), 32'(v.we));
      check({v.name, "_wmask"}, 32'(mem_wmask), 32'(v.exp_wmask));
      if (v.we) check({v.name, "_wdata"}, mem_wdata, v.exp_wdata);
      check({v.name, "_req_in_ready"}, 32'(in_ready), 32'd0);
      check({v.name, "_req_out_valid"}, 32'(out_valid), 32'd0);
      if (i == gnt_dly) mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
    end
    @(negedge clk);
    check({v.name, "_wait_req"}, 32'(mem_req), 32'd0);
    check({v.name, "_wait_out_valid"}, 32'(out_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = v.rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      check({v.name, "_out_valid"}, 32'(out_valid), 32'd1);
      check({v.name, "_out_rdata"}, out_rdata, v.exp_rdata);
      check({v.name, "_out_err"}, 32'(out_err), 32'd0);
      check({v.name, "_resp_in_ready"}, 32'(in_ready), 32'd0);
      if (i == rdy_dly) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    check({v.name, "_done_out_valid"}, 32'(out_valid), 32'd0);
    check({v.name, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_we = 1'b0; in_funct3 = 3'b010;
    out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //   name     we  f3      addr          wdata         rdata         mem_addr      mask     mem_wdata     out_rdata
    add("lw",     0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 32'h8000_0004, 4'b0000, 32'h0,        32'hDEAD_BEEF);
    add("lb",     0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFF_FF80);
    add("lbu",    0, 3'b100, 32'h8000_0003, 32'h0,        32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_0080);
    add("sh",     1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h1111_1111, 32'h8000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    add("lh0",    0, 3'b001, 32'h8000_0000, 32'h0,        32'h1234_F00D, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFF_F00D);
    add("lhu2",   0, 3'b101, 32'h8000_0002, 32'h0,        32'h8001_7FFF, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_8001);
    add("sb1",    1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 32'h2222_2222, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    add("sw",     1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h3333_3333, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0);
    add("lb1",    0, 3'b000, 32'h8000_0001, 32'h0,        32'h0000_7F00, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_007F);
    add("lunk",   0, 3'b011, 32'h8000_000C, 32'h0,        32'h1122_3344, 32'h8000_000C, 4'b0000, 32'h0,        32'h1122_3344);
    add("lh2",    0, 3'b001, 32'h8000_0006, 32'h0,        32'hA5A5_1234, 32'h8000_0004, 4'b0000, 32'h0,        32'hFFFF_A5A5);
    add("sb0",    1, 3'b000, 32'h8000_0000, 32'h0000_0012, 32'h0,        32'h8000_0000, 4'b0001, 32'h1212_1212, 32'h0);
`ifndef LSU_MISALIGN_CHECK_EN
    add("lw_mis", 0, 3'b010, 32'h8000_0002, 32'h0,        32'h0102_0304, 32'h8000_0000, 4'b0000, 32'h0,        32'h0102_0304);
    add("sh_mis", 1, 3'b001, 32'h8000_0003, 32'h0000_BEEF, 32'h0,        32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
`endif

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst_out_rdata", out_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i], 0, 0);

    // Stalled grant and stalled writeback
    run_txn(vecs[0], 3, 4);

    // Reset while waiting for rvalid
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h8000_0010; in_we = 1'b0; in_funct3 = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rwait_mem_req", 32'(mem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rwait_in_ready", 32'(in_ready), 32'd1);
    check("rwait_mem_req_rst", 32'(mem_req), 32'd0);
    check("rwait_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rwait_late_rvalid_out_valid", 32'(out_valid), 32'd0);
    check("rwait_late_rvalid_in_ready", 32'(in_ready), 32'd1);
    check("rwait_late_rvalid_req", 32'(mem_req), 32'd0);

    // Post-reset transaction still works
    run_txn(vecs[1], 1, 1);

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned word load: no bus request, immediate error response
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h8000_0002; in_we = 1'b0; in_funct3 = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mis_mem_req", 32'(mem_req), 32'd0);
    check("mis_out_valid", 32'(out_valid), 32'd1);
    check("mis_out_err", 32'(out_err), 32'd1);
    check("mis_out_rdata", out_rdata, 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("mis_done_out_valid", 32'(out_valid), 32'd0);
    check("mis_done_in_ready", 32'(in_ready), 32'd1);
    run_txn(vecs[0], 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
